// File: rtl/audiodac_fifo.sv
// Sample FIFO between the bus and the audio DAC modulator; converts to offset binary on write.
// Optional underflow counter output udf_cnt_o is enabled by defining AUDIODAC_FIFO_UDF_CNT_EN.
module audiodac_fifo #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned AEMPTY_LVL = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              tc_i,
    input  logic [15:0]       wr_data_i,
    input  logic              wr_en_i,
    input  logic              rd_i,
    output logic [15:0]       audio_o,
    output logic [ADDR_W:0]   level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              aempty_o,
    output logic              ovf_o,
    output logic              udf_o
`ifdef AUDIODAC_FIFO_UDF_CNT_EN
    ,
    output logic [7:0]        udf_cnt_o
`endif
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [15:0] MIDSCALE = 16'h8000;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic [15:0]       audio_q;
    logic              ovf_q, udf_q;
    logic              full, empty;
    logic              do_rd, wr_ok, ovf_ev, udf_ev;
    logic [15:0]       wr_word;

    // Level never exceeds DEPTH, so its top bit alone marks full.
    assign full  = level_q[ADDR_W];
    assign empty = (level_q == '0);

    assign do_rd   = rd_i && !empty;
    assign wr_ok   = wr_en_i && (!full || rd_i);
    assign ovf_ev  = wr_en_i && !wr_ok;
    assign udf_ev  = rd_i && empty;
    assign wr_word = {wr_data_i[15] ^ tc_i, wr_data_i[14:0]};

    always_comb begin
        level_d = level_q;
        unique case ({wr_ok, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            audio_q  <= MIDSCALE;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            audio_q  <= MIDSCALE;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                audio_q  <= mem[rd_ptr_q];
            end else if (rd_i) begin
                audio_q  <= MIDSCALE;
            end
            level_q <= level_d;
            if (ovf_ev) ovf_q <= 1'b1;
            if (udf_ev) udf_q <= 1'b1;
        end
    end

    // Storage is not reset; when full with a read, the head is read before being overwritten.
    always_ff @(posedge clk_i) begin
        if (wr_ok && !clr_i) mem[wr_ptr_q] <= wr_word;
    end

`ifdef AUDIODAC_FIFO_UDF_CNT_EN
    logic [7:0] udf_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            udf_cnt_q <= '0;
        end else if (clr_i) begin
            udf_cnt_q <= '0;
        end else if (udf_ev && udf_cnt_q != 8'hFF) begin
            udf_cnt_q <= udf_cnt_q + 8'd1;
        end
    end

    assign udf_cnt_o = udf_cnt_q;
`endif

    assign audio_o  = audio_q;
    assign level_o  = level_q;
    assign full_o   = full;
    assign empty_o  = empty;
    assign aempty_o = (32'(level_q) < AEMPTY_LVL);
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule
